rtc_read_sequencer: RTL and testbench
=====================================

// Module: rtc_read_sequencer
// PURPOSE
//  Upstream feeder of the digit-register bank (control_digitos_1).
//  Periodically sweeps the nine RTC time/date/timer registers over a simple
//  req/ack read bus.
//  For each register it presents one BCD nibble on dig0_Dec, the register
//  index on direccion and a one-cycle en_out strobe.
//  Pauses while the keyboard edit path (escribiendo) owns the registers.
// PARAMETERS
//  REFRESH_CYCLES  50_000_000  clk cycles between sweep starts (>= 64)
//  TIMEOUT_CYCLES  255         max clk cycles waiting for rd_ack per register
//  NIBBLE_SEL      0           0: dig0_Dec = rd_data[3:0]; 1: dig0_Dec = rd_data[7:4]
// PORTS
//  clk          in   1  system clock; every register is rising-edge triggered
//  reset        in   1  asynchronous, active-high reset
//  escribiendo  in   1  edit mode active; no new sweep or read may start
//  rd_req       out  1  read request, level; held until ack or timeout
//  rd_addr      out  8  RTC register address; stable while rd_req=1
//  rd_ack       in   1  read data valid; sampled only while rd_req=1
//  rd_data      in   8  BCD byte returned with rd_ack
//  en_out       out  1  one-cycle strobe: dig0_Dec/direccion valid
//  direccion    out  4  register index 0..8 (see address map)
//  dig0_Dec     out  4  selected BCD nibble of the captured byte
//  busy         out  1  sweep in progress
//  timeout_err  out  1  one-cycle pulse when a read times out
// BEHAVIOUR
//  Reset: every output is 0 immediately (async), FSM=IDLE, counters=0.
//   In-flight requests are dropped.
//  Address map (idx -> rd_addr):
//   0 hours 0x23; 1 min 0x22; 2 sec 0x21; 3 month 0x25; 4 day 0x24;
//   5 year 0x26; 6 timer hours 0x43; 7 timer min 0x42; 8 timer sec 0x41.
//  Refresh counter: free-running 0..REFRESH_CYCLES-1, wraps to 0.
//   At terminal count it sets sweep_pend.
//   sweep_pend clears when a sweep starts; a terminal count while pending is
//   absorbed (no queueing of more than one sweep).
//  FSM states: IDLE, REQ, WAIT, CAPT, NEXT.
//   IDLE: if sweep_pend & ~escribiendo -> REQ with idx=0, busy=1.
//   REQ:  rd_req=1, rd_addr=map(idx), timeout count=0 -> WAIT.
//   WAIT: if rd_ack -> CAPT, rd_req=0 the next cycle.
//         else if count==TIMEOUT_CYCLES -> timeout_err=1 for 1 cycle,
//         rd_req=0, no en_out -> NEXT.
//         else count++.
//   CAPT: en_out=1 for exactly 1 cycle; direccion=idx; dig0_Dec=nibble
//         -> NEXT.
//   NEXT: if idx==8 or escribiendo -> IDLE, busy=0.
//         else idx++ -> REQ.
//  Latency: en_out is asserted the cycle after rd_ack is sampled high.
//  direccion and dig0_Dec hold their last values between strobes.
//  Abort: escribiendo rising mid-sweep lets the current read finish (ack or
//   timeout), then returns to IDLE. The remaining indices are skipped.
//   sweep_pend is not re-set by the abort.
//  rd_ack while rd_req=0 is ignored. rd_ack in the same cycle as the timeout
//   terminal count: the ack wins.
//  Data are passed unmodified; no BCD validity check is performed
//   (0xF nibbles pass through; the consumer filters them).
// STRUCTURE
//  Shared package rtc_pkg:
//   - state encoding localparams
//   - RTC_ADDR[0:8] address table
//   - IDX_LAST=4'd8
//  Sub-module rtc_refresh_timer: refresh counter plus sweep_pend flag.
//  The FSM, index counter and timeout counter live in the top module.
// TESTING
//  1 Reset mid-WAIT (idx=3):
//    -> rd_req, en_out, busy = 0 in the same cycle.
//    -> After release, the next sweep starts at idx 0.
//  2 Full sweep, ack 2 cycles after each req, rd_data=0x59, NIBBLE_SEL=0:
//    -> 9 en_out strobes, direccion 0..8, dig0_Dec=9.
//    -> rd_addr sequence 23,22,21,25,24,26,43,42,41.
//  3 No ack at idx 4:
//    -> timeout_err pulses after 255 WAIT cycles.
//    -> No en_out for direccion 4; the sweep continues at 5.
//  4 escribiendo=1 during the idx 2 read:
//    -> The idx 2 strobe still occurs, then IDLE.
//    -> While escribiendo stays 1 no rd_req, even at terminal count.
//    -> The sweep starts once it drops.
//  5 REFRESH_CYCLES=64 with the sweep longer than 64 cycles:
//    -> Exactly one pending sweep starts right after the current one ends.
//  6 rd_ack and timeout in the same cycle:
//    -> Capture occurs (en_out=1) and timeout_err stays 0.

Source files
------------

// File: rtl/rtc_pkg.sv
// rtc_pkg: sequencer state encoding and the RTC register address map, indexed by display position
package rtc_pkg;
   typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_CAPT, ST_NEXT} state_t;
   localparam logic [3:0] IDX_LAST = 4'd8;
   localparam logic [7:0] RTC_ADDR [0:8] = '{8'h23, 8'h22, 8'h21, 8'h25, 8'h24, 8'h26, 8'h43, 8'h42, 8'h41};
endpackage

// File: rtl/rtc_read_sequencer_if.sv
// rtc_read_sequencer_if: req/ack read bus between the sequencer and the RTC register file
interface rtc_read_sequencer_if;
   logic       rd_req;
   logic [7:0] rd_addr;
   logic       rd_ack;
   logic [7:0] rd_data;
   modport master (output rd_req, rd_addr, input rd_ack, rd_data);
   modport slave (input rd_req, rd_addr, output rd_ack, rd_data);
endinterface

// File: rtl/rtc_refresh_timer.sv
// rtc_refresh_timer: free-running sweep period counter with a single-entry pending flag
module rtc_refresh_timer #(
   parameter int REFRESH_CYCLES = 50_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   output logic sweep_pend
);
   localparam int CW = $clog2(REFRESH_CYCLES);
   localparam logic [CW-1:0] TC = CW'(REFRESH_CYCLES - 1);
   logic [CW-1:0] cnt;
   logic tc;
   assign tc = cnt == TC;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         cnt <= '0;
         sweep_pend <= 1'b0;
      end else begin
         cnt <= tc ? '0 : cnt + 1'b1;
         // a terminal count on the very edge a sweep starts opens a new period, so it re-arms
         sweep_pend <= tc | (sweep_pend & ~start);
      end
endmodule

// File: rtl/rtc_read_sequencer.sv
// rtc_read_sequencer: sweeps the nine RTC registers and strobes one BCD nibble per register
module rtc_read_sequencer
   import rtc_pkg::*;
#(
   parameter int REFRESH_CYCLES = 50_000_000,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int NIBBLE_SEL     = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 escribiendo,
   rtc_read_sequencer_if.master bus,
   output logic                 en_out,
   output logic [3:0]           direccion,
   output logic [3:0]           dig0_Dec,
   output logic                 busy,
   output logic                 timeout_err
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   state_t state;
   logic [3:0] idx;
   logic [TW-1:0] tcnt;
   logic sweep_pend, start;
   assign start = state == ST_IDLE && sweep_pend && !escribiendo;
   rtc_refresh_timer #(.REFRESH_CYCLES(REFRESH_CYCLES)) u_timer (
      .clk(clk),
      .reset(reset),
      .start(start),
      .sweep_pend(sweep_pend)
   );
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= ST_IDLE;
         idx <= '0;
         tcnt <= '0;
         bus.rd_req <= 1'b0;
         bus.rd_addr <= '0;
         en_out <= 1'b0;
         direccion <= '0;
         dig0_Dec <= '0;
         busy <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         en_out <= 1'b0;
         timeout_err <= 1'b0;
         case (state)
            ST_IDLE: if (start) begin
               state <= ST_REQ;
               idx <= '0;
               busy <= 1'b1;
            end
            ST_REQ: begin
               bus.rd_req <= 1'b1;
               bus.rd_addr <= RTC_ADDR[idx];
               tcnt <= '0;
               state <= ST_WAIT;
            end
            // an ack arriving on the terminal count still wins over the timeout
            ST_WAIT: if (bus.rd_ack) begin
               bus.rd_req <= 1'b0;
               en_out <= 1'b1;
               direccion <= idx;
               dig0_Dec <= NIBBLE_SEL != 0 ? bus.rd_data[7:4] : bus.rd_data[3:0];
               state <= ST_CAPT;
            end else if (tcnt == TW'(TIMEOUT_CYCLES)) begin
               bus.rd_req <= 1'b0;
               timeout_err <= 1'b1;
               state <= ST_NEXT;
            end else
               tcnt <= tcnt + 1'b1;
            ST_CAPT: state <= ST_NEXT;
            ST_NEXT: if (idx == IDX_LAST || escribiendo) begin
               state <= ST_IDLE;
               busy <= 1'b0;
            end else begin
               idx <= idx + 1'b1;
               state <= ST_REQ;
            end
            default: state <= ST_IDLE;
         endcase
      end
endmodule

// File: tb/tb_rtc_read_sequencer.sv
// tb_rtc_read_sequencer: randomized req/ack responder checked against a transaction-level model
module tb_rtc_read_sequencer;
   localparam int REFRESH = 64;
   localparam int TMO = 255;
   typedef struct packed {
      logic        to;
      logic [3:0]  idx;
      logic [3:0]  nib;
      logic [31:0] at;
   } exp_t;
   logic clk = 1'b0, reset = 1'b1, escribiendo = 1'b0;
   logic en_out, busy, timeout_err;
   logic [3:0] direccion, dig0_Dec;
   logic [7:0] addr_map [0:8] = '{8'h23, 8'h22, 8'h21, 8'h25, 8'h24, 8'h26, 8'h43, 8'h42, 8'h41};
   exp_t q[$];
   exp_t e, e_new;
   int vectors = 0, miscompares = 0, cyc = 0;
   int mode = 0, noack_idx = -1, exact_idx = -1, exp_len = 9;
   int sweeps = 0, reqs = 0, total_reqs = 0, idx_m = 0;
   int prev_start = 0, end_m = 0, esc_free = 0;
   int k = 0, d = 0, cur_idx = 0, req_cyc = 0, snap = 0;
   bit active = 0, prev_busy = 0;
   logic [7:0] exp_addr = 8'h00, cur_data = 8'h00;
   logic [3:0] last_dir = 4'h0;
   rtc_read_sequencer_if bus();
   rtc_read_sequencer #(.REFRESH_CYCLES(REFRESH), .TIMEOUT_CYCLES(TMO), .NIBBLE_SEL(0)) dut (
      .clk(clk),
      .reset(reset),
      .escribiendo(escribiendo),
      .bus(bus),
      .en_out(en_out),
      .direccion(direccion),
      .dig0_Dec(dig0_Dec),
      .busy(busy),
      .timeout_err(timeout_err)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= reset ? 0 : cyc + 1;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, want, cyc);
      end
   endtask
   // a sweep starts one edge after the later of: the previous end, a terminal count at or
   // after the previous start, and the edit path releasing the registers
   function automatic int next_start();
      int t0 = ((prev_start > 0 ? prev_start : 1) + REFRESH - 1) / REFRESH * REFRESH;
      int p = end_m + 1;
      if (t0 + 1 > p) p = t0 + 1;
      if (esc_free > p) p = esc_free;
      return p;
   endfunction
   task automatic wait_sweeps(input int n);
      bit ok = 0;
      for (int i = 0; i < 6000 && !ok; i++) begin
         @(negedge clk);
         #2 ok = sweeps >= n;
      end
      chk("wait_sweep_done", ok, 1);
   endtask
   task automatic wait_idx(input int n);
      bit ok = 0;
      for (int i = 0; i < 6000 && !ok; i++) begin
         @(negedge clk);
         #2 ok = active && cur_idx == n;
      end
      chk("wait_req_idx", ok, 1);
   endtask
   initial begin
      bus.rd_ack = 1'b0;
      bus.rd_data = 8'h00;
      forever begin
         @(negedge clk);
         if (reset) begin
            q.delete();
            active = 0;
            prev_busy = 0;
            idx_m = 0;
            reqs = 0;
            prev_start = 0;
            end_m = 0;
            esc_free = 0;
            last_dir = 4'h0;
            bus.rd_ack = 1'b0;
         end else begin
            if (busy && !prev_busy) begin
               chk("sweep_start_cycle", cyc, next_start());
               chk("start_while_edit", escribiendo, 0);
               prev_start = cyc;
               idx_m = 0;
               reqs = 0;
            end
            if (!busy && prev_busy) begin
               chk("sweep_length", reqs, exp_len);
               end_m = cyc;
               sweeps++;
            end
            prev_busy = busy;
            if (en_out || timeout_err) begin
               if (q.size() == 0)
                  chk("unexpected_strobe", {en_out, timeout_err}, 0);
               else begin
                  e = q.pop_front();
                  chk("timeout_err", timeout_err, e.to);
                  chk("en_out", en_out, !e.to);
                  chk("strobe_cycle", cyc, e.at);
                  if (e.to)
                     chk("direccion_hold", direccion, last_dir);
                  else begin
                     chk("direccion", direccion, e.idx);
                     chk("dig0_Dec", dig0_Dec, e.nib);
                     last_dir = e.idx;
                  end
               end
            end
            if (active && !bus.rd_req) active = 0;
            if (bus.rd_req && !active) begin
               exp_addr = idx_m < 9 ? addr_map[idx_m] : 8'h00;
               chk("rd_addr", bus.rd_addr, exp_addr);
               chk("busy_during_req", busy, 1);
               cur_idx = idx_m;
               d = cur_idx == noack_idx ? 1000 : cur_idx == exact_idx ? TMO : mode == 0 ? 2 : $urandom_range(0, 5);
               cur_data = mode == 0 ? 8'h59 : 8'($urandom);
               e_new.to = d > TMO;
               e_new.idx = 4'(cur_idx);
               e_new.nib = cur_data[3:0];
               e_new.at = cyc + (d > TMO ? TMO : d) + 1;
               q.push_back(e_new);
               active = 1;
               k = 0;
               req_cyc = cyc;
               idx_m++;
               reqs++;
               total_reqs++;
            end else if (active)
               k++;
            if (active) begin
               bus.rd_ack = k == d;
               bus.rd_data = k == d ? cur_data : 8'($urandom);
               if (k == d) chk("rd_addr_stable", bus.rd_addr, exp_addr);
            end else begin
               bus.rd_ack = mode != 0 && $urandom_range(0, 3) == 0;
               bus.rd_data = 8'($urandom);
            end
         end
      end
   end
   initial begin
      repeat (3) @(negedge clk);
      #2;
      chk("rst_rd_req", bus.rd_req, 0);
      chk("rst_rd_addr", bus.rd_addr, 0);
      chk("rst_en_out", en_out, 0);
      chk("rst_direccion", direccion, 0);
      chk("rst_dig0_Dec", dig0_Dec, 0);
      chk("rst_busy", busy, 0);
      chk("rst_timeout_err", timeout_err, 0);
      reset = 1'b0;
      wait_sweeps(1);
      mode = 1;
      noack_idx = 4;
      wait_sweeps(2);
      noack_idx = -1;
      exact_idx = 6;
      wait_sweeps(3);
      exact_idx = -1;
      wait_sweeps(5);
      wait_idx(2);
      escribiendo = 1'b1;
      exp_len = 3;
      wait_sweeps(6);
      snap = total_reqs;
      repeat (200) @(negedge clk);
      #2 chk("no_req_while_edit", total_reqs, snap);
      escribiendo = 1'b0;
      esc_free = cyc + 1;
      exp_len = 9;
      wait_sweeps(8);
      wait_idx(3);
      chk("pre_reset_req", bus.rd_req, 1);
      reset = 1'b1;
      #1;
      chk("async_rst_rd_req", bus.rd_req, 0);
      chk("async_rst_en_out", en_out, 0);
      chk("async_rst_busy", busy, 0);
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;
      snap = sweeps;
      wait_sweeps(snap + 2);
      chk("queue_drained", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
